// File: rtl/mem_access_stage.sv
// MEM stage: branch decision, byte/half/word data memory with optional wait states, MEM/WB latch.
// Define MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning them.
module mem_access_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [1:0]  control_wb_in,
  input  logic [5:0]  m_ctl,
  input  logic        zero,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg_in,
  output logic        pcsrc,
  output logic        stall,
  output logic        wb_valid,
  output logic [1:0]  mem_control_wb,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  rd,
  output logic        misalign
);

  // state  | meaning
  // S_IDLE | new instruction presented; completes now unless wait states are needed
  // S_WAIT | memory access in progress, r_cnt counts elapsed wait cycles
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam bit         HAS_WAIT = (LATENCY != 0);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [DEPTH] = '{default: '0};

  logic        r_wb_valid, r_misalign;
  logic [1:0]  r_ctl_wb;
  logic [31:0] r_read_data, r_alu_result;
  logic [4:0]  r_rd;

  logic        w_memwrite, w_memread, w_branch, w_unsigned;
  logic        w_is_byte, w_is_half, w_mem_op, w_misalign, w_access;
  logic        w_complete, w_store;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata, w_word, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_memwrite = m_ctl[0];
  assign w_memread  = m_ctl[1];
  assign w_branch   = m_ctl[2];
  assign w_unsigned = m_ctl[5];
  assign w_is_byte  = (m_ctl[4:3] == 2'b00);
  assign w_is_half  = (m_ctl[4:3] == 2'b01);
  assign w_mem_op   = valid_in & (w_memread | w_memwrite);
  assign w_idx      = address[AW+1:2];
  assign w_unused   = &{1'b0, address[31:AW+2]};

  assign pcsrc = valid_in & w_branch & zero;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & ((w_is_half & address[0]) |
                                  (m_ctl[4] & (address[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = w_mem_op & ~w_misalign;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    stall       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && HAS_WAIT) begin
          stall       = 1'b1;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = S_WAIT;
        end else begin
          w_complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAT) begin
          w_complete  = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else begin
          stall     = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Narrow stores replicate the data across lanes; the mask picks the lanes that change.
  always_comb begin
    w_wmask = 4'hF;
    w_wdata = write_data;
    if (w_is_byte) begin
      w_wmask = 4'b0001 << address[1:0];
      w_wdata = {4{write_data[7:0]}};
    end else if (w_is_half) begin
      w_wmask = address[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{write_data[15:0]}};
    end
  end

  assign w_store = w_access & w_memwrite & w_complete & ~reset;

  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{address[1:0], 3'b000} +: 8];
  assign w_half = address[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = 32'd0;
    if (w_access && w_memread && !w_memwrite) begin
      if (w_is_byte)      w_load = {{24{~w_unsigned & w_byte[7]}}, w_byte};
      else if (w_is_half) w_load = {{16{~w_unsigned & w_half[15]}}, w_half};
      else                w_load = w_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid   <= 1'b0;
      r_ctl_wb     <= 2'd0;
      r_read_data  <= 32'd0;
      r_alu_result <= 32'd0;
      r_rd         <= 5'd0;
      r_misalign   <= 1'b0;
    end else if (w_complete && valid_in) begin
      r_wb_valid   <= 1'b1;
      r_ctl_wb     <= control_wb_in;
      r_read_data  <= w_load;
      r_alu_result <= address;
      r_rd         <= write_reg_in;
      r_misalign   <= w_misalign;
    end else begin
      r_wb_valid <= 1'b0;
      r_ctl_wb   <= 2'd0;
    end
  end

  assign wb_valid       = r_wb_valid;
  assign mem_control_wb = r_ctl_wb;
  assign read_data      = r_read_data;
  assign mem_alu_result = r_alu_result;
  assign rd             = r_rd;
  assign misalign       = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one zero-latency and one 3-wait-state instance against a byte-array model.
module tb_mem_access_stage;
  localparam int DEPTH = 256;
  localparam int BYTES = 4 * DEPTH;

  localparam logic [5:0] SW  = 6'b010001;
  localparam logic [5:0] LW  = 6'b010010;
  localparam logic [5:0] SB  = 6'b000001;
  localparam logic [5:0] LB  = 6'b000010;
  localparam logic [5:0] LBU = 6'b100010;
  localparam logic [5:0] LH  = 6'b001010;
  localparam logic [5:0] LHU = 6'b101010;
  localparam logic [5:0] BR  = 6'b000100;

  logic        clk = 1'b0, reset = 1'b1, valid0 = 1'b0, valid3 = 1'b0, zero = 1'b0;
  logic [1:0]  ctl_wb = 2'd0;
  logic [5:0]  m_ctl = 6'd0;
  logic [31:0] address = 32'd0, wdata = 32'd0;
  logic [4:0]  wreg = 5'd0;

  logic        pc0, st0, wbv0, mis0, pc3, st3, wbv3, mis3;
  logic [1:0]  mcw0, mcw3;
  logic [31:0] rdat0, alu0, rdat3, alu3;
  logic [4:0]  rd0, rd3;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] bm [2][BYTES];

  mem_access_stage #(.DEPTH(DEPTH), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .valid_in(valid0), .control_wb_in(ctl_wb), .m_ctl(m_ctl),
    .zero(zero), .address(address), .write_data(wdata), .write_reg_in(wreg),
    .pcsrc(pc0), .stall(st0), .wb_valid(wbv0), .mem_control_wb(mcw0), .read_data(rdat0),
    .mem_alu_result(alu0), .rd(rd0), .misalign(mis0));

  mem_access_stage #(.DEPTH(DEPTH), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .valid_in(valid3), .control_wb_in(ctl_wb), .m_ctl(m_ctl),
    .zero(zero), .address(address), .write_data(wdata), .write_reg_in(wreg),
    .pcsrc(pc3), .stall(st3), .wb_valid(wbv3), .mem_control_wb(mcw3), .read_data(rdat3),
    .mem_alu_result(alu3), .rd(rd3), .misalign(mis3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_mis(input logic [5:0] mc, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (!(mc[0] | mc[1])) return 1'b0;
    if (mc[4:3] == 2'b00) return 1'b0;
    if (mc[4:3] == 2'b01) return a[0];
    return (a[1:0] != 2'b00);
`else
    return (mc[0] & 1'b0) | (a[0] & 1'b0);
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  task automatic check_reset(input int sel);
    chk("rst_wb_valid", 32'(sel ? wbv3 : wbv0), 32'd0);
    chk("rst_ctl", 32'(sel ? mcw3 : mcw0), 32'd0);
    chk("rst_read_data", sel ? rdat3 : rdat0, 32'd0);
    chk("rst_alu", sel ? alu3 : alu0, 32'd0);
    chk("rst_rd", 32'(sel ? rd3 : rd0), 32'd0);
    chk("rst_misalign", 32'(sel ? mis3 : mis0), 32'd0);
    chk("rst_stall", 32'(sel ? st3 : st0), 32'd0);
  endtask

  // One instruction through instance sel (0: LATENCY 0, 1: LATENCY 3), checked cycle by cycle.
  task automatic op(input int sel, input logic [5:0] mc, input logic z, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] cw, input logic [4:0] r);
    int nb, ea, nwait;
    bit memop, mis;
    logic [31:0] v;
    nb    = nbytes(mc[4:3]);
    memop = mc[0] | mc[1];
    mis   = exp_mis(mc, a);
    ea    = int'(a % 32'(BYTES));
    ea    = ea - (ea % nb);
    v     = 32'd0;
    for (int i = 0; i < nb; i++) v |= 32'(bm[sel][ea+i]) << (8*i);
    if (nb < 4 && !mc[5] && v[8*nb-1]) v |= ~((32'd1 << (8*nb)) - 32'd1);
    if (mc[0] || !mc[1] || mis) v = 32'd0;
    nwait = (sel == 1 && memop && !mis) ? 3 : 0;

    @(negedge clk);
    m_ctl = mc; zero = z; address = a; wdata = d; ctl_wb = cw; wreg = r;
    valid0 = (sel == 0);
    valid3 = (sel == 1);
    #1;
    chk("pcsrc", 32'(sel ? pc3 : pc0), 32'(mc[2] & z));
    for (int k = 0; k < nwait; k++) begin
      chk("stall_hi", 32'(st3), 32'd1);
      @(posedge clk); #1;
      chk("bubble_valid", 32'(wbv3), 32'd0);
      chk("bubble_ctl", 32'(mcw3), 32'd0);
    end
    chk("stall_lo", 32'(sel ? st3 : st0), 32'd0);
    @(posedge clk); #1;
    if (mc[0] && !mis) for (int i = 0; i < nb; i++) bm[sel][ea+i] = 8'(d >> (8*i));
    chk("wb_valid", 32'(sel ? wbv3 : wbv0), 32'd1);
    chk("wb_ctl", 32'(sel ? mcw3 : mcw0), 32'(cw));
    chk("alu_result", sel ? alu3 : alu0, a);
    chk("rd", 32'(sel ? rd3 : rd0), 32'(r));
    if (memop) chk("misalign", 32'(sel ? mis3 : mis0), 32'(mis));
    if (mc[1]) chk("read_data", sel ? rdat3 : rdat0, v);
    valid0 = 1'b0;
    valid3 = 1'b0;
  endtask

  initial begin
    logic [5:0]  rmc;
    logic [31:0] ra;
    int          rsel, rkind;
    for (int s = 0; s < 2; s++) for (int b = 0; b < BYTES; b++) bm[s][b] = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    reset = 1'b0;

    op(0, SW, 1'b0, 32'h10, 32'hDEADBEEF, 2'b01, 5'd3);
    op(0, LW, 1'b0, 32'h10, 32'h0, 2'b11, 5'd4);
    op(0, SW, 1'b0, 32'h10, 32'h11223344, 2'b00, 5'd0);
    op(0, SB, 1'b0, 32'h13, 32'h000000AB, 2'b00, 5'd0);
    op(0, LW, 1'b0, 32'h10, 32'h0, 2'b10, 5'd5);
    op(0, LB, 1'b0, 32'h13, 32'h0, 2'b10, 5'd6);
    op(0, LBU, 1'b0, 32'h13, 32'h0, 2'b10, 5'd7);
    op(0, LH, 1'b0, 32'h12, 32'h0, 2'b10, 5'd8);
    op(0, LHU, 1'b0, 32'h12, 32'h0, 2'b10, 5'd9);
    op(0, BR, 1'b1, 32'h40, 32'h0, 2'b00, 5'd0);
    op(0, BR, 1'b0, 32'h40, 32'h0, 2'b00, 5'd0);
    op(0, SW, 1'b0, 32'h400, 32'h77, 2'b00, 5'd0);
    op(0, LW, 1'b0, 32'h0, 32'h0, 2'b01, 5'd10);
    op(0, LW, 1'b0, 32'h2, 32'h0, 2'b01, 5'd11);

    op(1, SW, 1'b0, 32'h20, 32'h1234, 2'b00, 5'd0);
    op(1, LW, 1'b0, 32'h20, 32'h0, 2'b11, 5'd12);

    // Reset arrives on the second stall cycle of a store; the store must be dropped.
    @(negedge clk);
    m_ctl = SW; address = 32'h20; wdata = 32'h5; ctl_wb = 2'b11; wreg = 5'd1; zero = 1'b0;
    valid3 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    valid3 = 1'b0;
    #1;
    check_reset(1);
    @(negedge clk);
    reset = 1'b0;
    op(1, LW, 1'b0, 32'h20, 32'h0, 2'b01, 5'd13);

    repeat (80) begin
      rsel  = int'($urandom_range(0, 1));
      rkind = int'($urandom_range(0, 3));
      rmc[5]   = 1'($urandom_range(0, 1));
      rmc[4:3] = 2'($urandom_range(0, 3));
      rmc[2]   = 1'($urandom_range(0, 1));
      rmc[1:0] = (rkind == 0) ? 2'b10 : (rkind == 1) ? 2'b01 : (rkind == 2) ? 2'b11 : 2'b00;
      ra = {22'($urandom), 5'd0, 5'($urandom_range(0, 31))};
      op(rsel, rmc, 1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
         5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
